// File: rtl/dist3_8_pkg.sv
// Shared constants, slot state encoding and bit-count helper for the dist3_8 distributor.
package dist3_8_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int SEL_W     = 3;
    localparam int NSLOTS    = 8;
    localparam int OCC_W     = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [OCC_W-1:0] popcount8(input logic [NSLOTS-1:0] v);
        logic [OCC_W-1:0] c;
        c = 4'd0;
        for (int i = 0; i < NSLOTS; i++) begin
            c = c + {{(OCC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/dist3_8_slot.sv
// One distributor slot: holds a word from load until its consumer acks it.
module dist_slot
    import dist3_8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    slot_state_e      state_r;
    slot_state_e      state_s;
    logic [WIDTH-1:0] data_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Data register: changes only on load, otherwise holds the last word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= din;
        end else begin
            data_r <= data_r;
        end
    end

    // Next-state: a load together with an ack keeps the slot full (refill)
    always_comb begin
        state_s = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load) state_s = SLOT_FULL;
                else      state_s = SLOT_EMPTY;
            end
            SLOT_FULL: begin
                if (ack && !load) state_s = SLOT_EMPTY;
                else              state_s = SLOT_FULL;
            end
            default: state_s = SLOT_EMPTY;
        endcase
    end

    // Outputs straight from registers
    always_comb begin
        valid = (state_r == SLOT_FULL);
        dout  = data_r;
    end

endmodule

// File: rtl/dist3_8.sv
// Registered 1-to-8 distributor. Define DIST3_8_OVERWRITE_EN to let writes to a
// full slot overwrite it (in_ready constant 1, sticky overflow flag).
module dist3_8
    import dist3_8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   selector,
    input  logic [WIDTH-1:0]   data_in,
    output logic               in_ready,
    input  logic [NSLOTS-1:0]  ack,
    output logic [NSLOTS-1:0]  slot_valid,
    output logic [WIDTH-1:0]   data_out_0,
    output logic [WIDTH-1:0]   data_out_1,
    output logic [WIDTH-1:0]   data_out_2,
    output logic [WIDTH-1:0]   data_out_3,
    output logic [WIDTH-1:0]   data_out_4,
    output logic [WIDTH-1:0]   data_out_5,
    output logic [WIDTH-1:0]   data_out_6,
    output logic [WIDTH-1:0]   data_out_7,
    output logic [OCC_W-1:0]   occupancy,
    output logic               overflow
);

    logic [NSLOTS-1:0] load_s;
    logic [NSLOTS-1:0] next_valid_s;
    logic [WIDTH-1:0]  dout_s [NSLOTS];
    logic [OCC_W-1:0]  occupancy_r;

`ifdef DIST3_8_OVERWRITE_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = !slot_valid[selector] || ack[selector];
`endif

    // Load decode and predicted next slot_valid so occupancy updates on the same edge
    always_comb begin
        load_s       = {NSLOTS{1'b0}};
        next_valid_s = {NSLOTS{1'b0}};
        for (int k = 0; k < NSLOTS; k++) begin
            load_s[k]       = in_valid && in_ready && (selector == SEL_W'(k));
            next_valid_s[k] = load_s[k] || (slot_valid[k] && !ack[k]);
        end
    end

    for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
        dist_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load_s[k]),
            .ack   (ack[k]),
            .din   (data_in),
            .dout  (dout_s[k]),
            .valid (slot_valid[k])
        );
    end

    // Occupancy register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy_r <= 4'd0;
        end else begin
            occupancy_r <= popcount8(next_valid_s);
        end
    end

`ifdef DIST3_8_OVERWRITE_EN
    logic overflow_r;

    // Sticky overflow: a load into a full slot that is not being acked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r || (|(load_s & slot_valid & ~ack));
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    assign occupancy  = occupancy_r;
    assign data_out_0 = dout_s[0];
    assign data_out_1 = dout_s[1];
    assign data_out_2 = dout_s[2];
    assign data_out_3 = dout_s[3];
    assign data_out_4 = dout_s[4];
    assign data_out_5 = dout_s[5];
    assign data_out_6 = dout_s[6];
    assign data_out_7 = dout_s[7];

endmodule

// File: tb/tb_dist3_8.sv
// Directed self-checking bench for dist3_8 (covers DIST3_8_OVERWRITE_EN when defined).
module tb_dist3_8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  selector;
    logic [31:0] data_in;
    logic        in_ready;
    logic [7:0]  ack;
    logic [7:0]  slot_valid;
    logic [31:0] dout [8];
    logic [3:0]  occupancy;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dist3_8 dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .selector   (selector),
        .data_in    (data_in),
        .in_ready   (in_ready),
        .ack        (ack),
        .slot_valid (slot_valid),
        .data_out_0 (dout[0]),
        .data_out_1 (dout[1]),
        .data_out_2 (dout[2]),
        .data_out_3 (dout[3]),
        .data_out_4 (dout[4]),
        .data_out_5 (dout[5]),
        .data_out_6 (dout[6]),
        .data_out_7 (dout[7]),
        .occupancy  (occupancy),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one rising edge, then back to the falling edge for driving/sampling
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        selector = 3'd2;
        data_in  = 32'h0000_0ABC;
        ack      = 8'h00;

        // reset held with an offer present
        step(); step();
        chk("rst_slot_valid", {24'h0, slot_valid}, 32'h0);
        chk("rst_occupancy", {28'h0, occupancy}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_dout%0d", k), dout[k], 32'h0);

        reset    = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            selector = 3'(k);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", k), {31'h0, in_ready}, 32'h1);
        end

        // fill all eight slots
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            selector = 3'(k);
            data_in  = 32'h100 + 32'(k);
            step();
            chk($sformatf("fill_occ%0d", k), {28'h0, occupancy}, 32'(k + 1));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) chk($sformatf("fill_dout%0d", k), dout[k], 32'h100 + 32'(k));
        chk("fill_slot_valid", {24'h0, slot_valid}, 32'hFF);
        chk("fill_occupancy", {28'h0, occupancy}, 32'h8);

`ifndef DIST3_8_OVERWRITE_EN
        // stall on full slot 3, then accept on the ack edge
        in_valid = 1'b1;
        selector = 3'd3;
        data_in  = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            step();
            chk("stall_dout3", dout[3], 32'h103);
        end
        ack = 8'h08;
        #1;
        chk("stall_ack_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        ack      = 8'h00;
        in_valid = 1'b0;
        chk("stall_dout3_new", dout[3], 32'hDEAD);
        chk("stall_slot_valid", {24'h0, slot_valid}, 32'hFF);
        chk("stall_occupancy", {28'h0, occupancy}, 32'h8);
        chk("no_overflow", {31'h0, overflow}, 32'h0);
`else
        // empty slot 1, load 0x11, then overwrite with 0x22 without ack
        ack = 8'h02;
        step();
        ack      = 8'h00;
        in_valid = 1'b1;
        selector = 3'd1;
        data_in  = 32'h11;
        step();
        chk("ovw_dout1_first", dout[1], 32'h11);
        chk("ovw_no_overflow_yet", {31'h0, overflow}, 32'h0);
        data_in = 32'h22;
        #1;
        chk("ovw_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        chk("ovw_dout1", dout[1], 32'h22);
        chk("ovw_overflow", {31'h0, overflow}, 32'h1);
        chk("ovw_slot_valid", {24'h0, slot_valid}, 32'hFF);
        chk("ovw_occupancy", {28'h0, occupancy}, 32'h8);
        step();
        chk("ovw_overflow_sticky", {31'h0, overflow}, 32'h1);
`endif

        // simultaneous ack and refill of slot 5
        in_valid = 1'b1;
        selector = 3'd5;
        data_in  = 32'h55;
        ack      = 8'h20;
        #1;
        chk("sim_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        ack      = 8'h00;
        chk("sim_dout5", dout[5], 32'h55);
        chk("sim_slot_valid", {24'h0, slot_valid}, 32'hFF);
        chk("sim_occupancy", {28'h0, occupancy}, 32'h8);

        // drain everything; data must hold
        ack = 8'hFF;
        step();
        ack = 8'h00;
        chk("drain_slot_valid", {24'h0, slot_valid}, 32'h0);
        chk("drain_occupancy", {28'h0, occupancy}, 32'h0);
        chk("drain_dout5_hold", dout[5], 32'h55);

        // in_valid low: nothing happens
        selector = 3'd4;
        data_in  = 32'hBAD0;
        step();
        chk("idle_slot_valid", {24'h0, slot_valid}, 32'h0);
        chk("idle_dout4", dout[4], 32'h104);

        // multi-ack with only slots 0 and 2 full
        in_valid = 1'b1;
        selector = 3'd0;
        data_in  = 32'hA0;
        step();
        selector = 3'd2;
        data_in  = 32'hA2;
        step();
        in_valid = 1'b0;
        chk("mack_pre_valid", {24'h0, slot_valid}, 32'h05);
        chk("mack_pre_occ", {28'h0, occupancy}, 32'h2);
        ack = 8'hA5;
        step();
        ack = 8'h00;
        chk("mack_slot_valid", {24'h0, slot_valid}, 32'h00);
        chk("mack_occupancy", {28'h0, occupancy}, 32'h0);
        chk("mack_dout0_hold", dout[0], 32'hA0);
        chk("mack_dout2_hold", dout[2], 32'hA2);

        // asynchronous reset mid-cycle clears everything without a clock edge
        in_valid = 1'b1;
        selector = 3'd6;
        data_in  = 32'h66;
        step();
        chk("pre_rst_valid", {24'h0, slot_valid}, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_slot_valid", {24'h0, slot_valid}, 32'h0);
        chk("arst_dout6", dout[6], 32'h0);
        chk("arst_occupancy", {28'h0, occupancy}, 32'h0);
        chk("arst_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("post_rst_valid", {24'h0, slot_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dist3_8.md
# dist3_8

Registered 1-to-8 distributor: the write-side counterpart of the 3-bit-select result muxes in the multicycle datapath. A single 32-bit producer offers a word plus a 3-bit destination selector under a valid/ready handshake; the word is latched into one of eight output slots, each holding its data until its consumer acknowledges it. The block sits between the ALU/memory result path and the per-destination consumers (register write-back, PC load, EPC/exception capture, and similar), decoupling producer and consumer timing.

## Interface
- WIDTH, 32, data width of input and every slot
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- in_valid  in  1  producer offers data_in to slot selector
- selector  in  3  destination slot index 0..7
- data_in  in  WIDTH  word to deliver
- in_ready  out  1  block accepts the offer this cycle
- ack  in  8  ack[k]: consumer k takes slot k this cycle
- slot_valid  out  8  slot_valid[k]: slot k holds an undelivered word
- data_out_0 … data_out_7  out  WIDTH each  registered slot contents
- occupancy  out  4  number of set bits in slot_valid (0..8), registered
- overflow  out  1  sticky flag, set on an overwrite (only with macro)

## Operation
- Transfer occurs when in_valid && in_ready at a rising edge; the word goes to slot selector only; other slots unchanged.
- in_ready = !slot_valid[selector] || ack[selector] (combinational; no dependence on in_valid).
- Slot k state: EMPTY (slot_valid[k]=0) / FULL (slot_valid[k]=1).
  - EMPTY -> FULL on transfer to k.
  - FULL -> EMPTY on ack[k] without transfer to k.
  - FULL -> FULL with new data on ack[k] and transfer to k in the same cycle (pass-through refill).
  - ack[k] while EMPTY: ignored, no state change.
- data_out_k changes only on transfer to k; after ack it keeps the last word (don't-care for consumers, but must hold).
- occupancy tracks slot_valid exactly, updated in the same edge.
- in_valid low: selector/data_in ignored, no state change.
- Multiple ack bits may be set in one cycle; each slot handles its own independently.

## Timing
- Reset (asynchronous assert, reset low): slot_valid=8'h00, all data_out_k=0, occupancy=0, overflow=0; in_ready then equals 1 for any selector.
- Reset deassertion is synchronised externally; a reset pulse mid-transfer discards the pending word and all held slots.
- Latency: word accepted at edge N is visible on data_out_k and slot_valid[k] after edge N (one cycle).
- Ack at edge N clears slot_valid[k] after edge N; consumer must sample data_out_k in the cycle it asserts ack[k].
- in_ready is combinational from selector, slot_valid and ack; producer must hold in_valid/selector/data_in stable until accepted.
- Throughput: one word per cycle when target slots are empty or acked concurrently.

## Configuration
- DIST3_8_OVERWRITE_EN defined: in_ready is constant 1; a transfer to a FULL slot without ack replaces its data, keeps slot_valid=1, and sets overflow (sticky until reset). occupancy unchanged by an overwrite.
- Not defined: stall behaviour above; overflow output tied to 0.

## Structure
- Shared package: WIDTH default (32), SEL_W=3, NSLOTS=8, occupancy width (4).
- One sub-module, dist_slot: single slot register (load, ack, data, valid); instantiated eight times with a 3-to-8 load decode at top level.
- Top level holds the decode, in_ready logic, occupancy counter, overflow flag.

## Test plan
- Reset: hold reset=0 with in_valid=1 -> slot_valid=0, occupancy=0, all data_out=0; release, in_ready=1 for selector 0..7.
- Fill: write 32'h100+k to slot k for k=0..7 over 8 cycles -> data_out_k=32'h100+k, slot_valid=8'hFF, occupancy=8.
- Stall: slot 3 full, offer 32'hDEAD to selector 3, ack=0 for 4 cycles -> in_ready=0, data_out_3 unchanged; assert ack[3] -> accepted that edge, data_out_3=32'hDEAD, slot_valid[3]=1.
- Simultaneous: slot 5 full, ack[5]=1 and transfer 32'h55 to slot 5 same cycle -> slot_valid[5] stays 1, data_out_5=32'h55, occupancy unchanged.
- Multi-ack and empty-ack: ack=8'hA5 with slots 0,2 full only -> slots 0,2 emptied, others unchanged, occupancy drops by 2.
- Overwrite (macro defined): slot 1 full with 32'h11, write 32'h22 to slot 1 no ack -> in_ready=1, data_out_1=32'h22, overflow=1 until reset.
